mmio_io_responder: RTL

MMIO_IO_RESPONDER -- requirements
Module: mmio_io_responder

---
 rtl/io_map.sv | 31 +++
 rtl/io_out_fifo.sv | 70 +++++++
 rtl/mmio_io_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/io_map.sv
// Shared MMIO map for the button/display responder: default addresses,
// button bit positions and the layout of the output status word.
package io_map;

    localparam int unsigned ADDR_BTNC_DEF = 1000;
    localparam int unsigned ADDR_OUT_DEF  = 2000;
    localparam int unsigned ADDR_BTNL_DEF = 3000;
    localparam int unsigned ADDR_BTNR_DEF = 4000;
    localparam int unsigned ADDR_BTNU_DEF = 5000;
    localparam int unsigned ADDR_BTND_DEF = 6000;

    localparam int unsigned NUM_BTN   = 5;
    localparam int unsigned BTN_C     = 0;
    localparam int unsigned BTN_D     = 1;
    localparam int unsigned BTN_L     = 2;
    localparam int unsigned BTN_R     = 3;
    localparam int unsigned BTN_U     = 4;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STAT_CNT_W = 5;

    // Status word returned by a load of the output-FIFO address.
    typedef struct packed {
        logic [22:0]           rsvd_hi;
        logic [STAT_CNT_W-1:0] count;
        logic [1:0]            rsvd_lo;
        logic                  overflow;
        logic                  full;
    } io_status_t;

endpackage

// File: rtl/io_out_fifo.sv
// Output FIFO feeding the display consumer.
// Ports: clock/reset (async active-low), push/pop strobes, din/dout data,
// full/empty flags and occupancy count. Caller must not push when full
// unless popping in the same cycle, and must not pop when empty.
module io_out_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer/count next state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while count > 0.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder: sticky button-press events readable (and
// cleared) by loads, plus a store-fed output FIFO for a display consumer.
// Ports: clock/reset (async active-low); address_dmem/wren/data processor
// access; btn debounced levels; q_io/io_hit registered load response;
// out_data/out_valid/out_ready consumer handshake; out_overflow sticky flag.
module mmio_io_responder
    import io_map::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_BTNC  = ADDR_BTNC_DEF,
    parameter int unsigned ADDR_OUT   = ADDR_OUT_DEF,
    parameter int unsigned ADDR_BTNL  = ADDR_BTNL_DEF,
    parameter int unsigned ADDR_BTNR  = ADDR_BTNR_DEF,
    parameter int unsigned ADDR_BTNU  = ADDR_BTNU_DEF,
    parameter int unsigned ADDR_BTND  = ADDR_BTND_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   address_dmem,
    input  logic                wren,
    input  logic [DATA_W-1:0]   data,
    input  logic [NUM_BTN-1:0]  btn,
    output logic [DATA_W-1:0]   q_io,
    output logic                io_hit,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_BTN-1:0] btn_prev_q;
    logic [NUM_BTN-1:0] evt_q, evt_d;
    logic [NUM_BTN-1:0] btn_edge_c, btn_sel_c, seen_c;
    logic [DATA_W-1:0]  q_io_q, q_io_d;
    logic               io_hit_q, io_hit_d;
    logic               ovf_q, ovf_d;
    logic               out_sel_c, push_c, pop_c;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;
    io_status_t         status_c;

    // Rising-edge detect and one-hot button-address decode (loads only).
    assign btn_edge_c = btn & ~btn_prev_q;
    assign seen_c     = evt_q | btn_edge_c;
    assign out_sel_c  = (address_dmem == 32'(ADDR_OUT));
    assign btn_sel_c  = {NUM_BTN{~wren}} & {
        (address_dmem == 32'(ADDR_BTNU)),
        (address_dmem == 32'(ADDR_BTNR)),
        (address_dmem == 32'(ADDR_BTNL)),
        (address_dmem == 32'(ADDR_BTND)),
        (address_dmem == 32'(ADDR_BTNC))
    };

    // A coincident edge is reported by the load and consumed with the event.
    assign evt_d = seen_c & ~btn_sel_c;

    // FIFO control: a store while full is accepted only if a pop frees a slot.
    assign pop_c  = out_valid & out_ready;
    assign push_c = wren & out_sel_c & (~fifo_full | pop_c);
    assign ovf_d  = ovf_q | (wren & out_sel_c & fifo_full & ~pop_c);

    always_comb begin
        status_c          = '0;
        status_c.full     = fifo_full;
        status_c.overflow = ovf_q;
        status_c.count    = STAT_CNT_W'(fifo_count);
    end

    // Load response mux.
    always_comb begin
        q_io_d   = '0;
        io_hit_d = 1'b0;
        if (|btn_sel_c) begin
            q_io_d   = {31'b0, |(seen_c & btn_sel_c)};
            io_hit_d = 1'b1;
        end else if (!wren && out_sel_c) begin
            q_io_d   = status_c;
            io_hit_d = 1'b1;
        end
    end

    // All-ones reset of btn_prev suppresses events for buttons held through reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_prev_q <= '1;
            evt_q      <= '0;
            q_io_q     <= '0;
            io_hit_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            btn_prev_q <= btn;
            evt_q      <= evt_d;
            q_io_q     <= q_io_d;
            io_hit_q   <= io_hit_d;
            ovf_q      <= ovf_d;
        end
    end

    io_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (data),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign q_io         = q_io_q;
    assign io_hit       = io_hit_q;
    assign out_valid    = ~fifo_empty;
    assign out_overflow = ovf_q;

endmodule
